// File: rtl/mem_fetch_unit.sv
// mem_fetch_unit: memory-side stage of the multicycle RISC-V datapath.
// Owns PC, OldPC, the instruction register and the memory data register,
// and runs a request/grant/response handshake to a unified memory.
// Optional feature: define MEM_TIMEOUT_EN to abort accesses that wait
// TIMEOUT_CYCLES cycles without completing (mem_err pulse, no done).
module mem_fetch_unit #(
  parameter int unsigned     XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_PC       = '0,
  parameter int unsigned     TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic            adr_src,
  input  logic            mem_write,
  input  logic            ir_write,
  input  logic            acc_start,
  input  logic [XLEN-1:0] pc_next,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] write_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] old_pc,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] data,
  output logic            busy,
  output logic            done,
  output logic            mem_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Latched access attributes, held stable for the whole access
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            we_q;
  logic            fetch_q;
  logic            done_q;
  logic            err_q;

  logic [XLEN-1:0] start_addr;
  logic            start_misaligned;
  logic            start_ok;
  logic            rd_done;
  logic            wr_done;
  logic            timeout;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] tmo_cnt;

  // Wait counter: zero while idle so it starts from zero on entry to REQ
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end
`endif

  // Next-state logic and completion/abort decode for the handshake
  always_comb begin
    state_next       = state;
    start_addr       = adr_src ? alu_out : pc;
    start_misaligned = 1'b0;
    start_ok         = 1'b0;
    rd_done          = 1'b0;
    wr_done          = 1'b0;
    timeout          = 1'b0;
    case (state)
      IDLE: begin
        if (acc_start) begin
          if (start_addr[1:0] != 2'b00) begin
            start_misaligned = 1'b1;
          end else begin
            start_ok   = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          if (we_q) begin
            wr_done    = 1'b1;
            state_next = IDLE;
          end else if (mem_rvalid) begin
            rd_done    = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = RESP;
          end
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          rd_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
`ifdef MEM_TIMEOUT_EN
    // A completion in the limit cycle wins over the abort
    if ((state != IDLE) && (tmo_cnt == LIMIT) && !(rd_done || wr_done)) begin
      timeout    = 1'b1;
      state_next = IDLE;
    end
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Architectural registers, access latches and one-cycle status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      old_pc  <= '0;
      instr   <= '0;
      data    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      fetch_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (pc_write) begin
        pc <= pc_next;
      end
      done_q <= rd_done | wr_done;
      err_q  <= start_misaligned | timeout;
      if ((state == IDLE) && acc_start) begin
        addr_q  <= start_addr;
        wdata_q <= write_data;
        we_q    <= mem_write;
        fetch_q <= ir_write & ~mem_write;
      end
      if (rd_done) begin
        if (fetch_q) begin
          instr  <= mem_rdata;
          old_pc <= addr_q;
        end else begin
          data <= mem_rdata;
        end
      end
    end
  end

  assign mem_req   = (state == REQ);
  assign mem_we    = (state == REQ) & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign mem_err   = err_q;

  // start_ok documents the accepted-start decode; it mirrors the IDLE->REQ move
  logic unused_start_ok;
  assign unused_start_ok = start_ok;

endmodule

// File: tb/tb_mem_fetch_unit.sv
// Testbench for mem_fetch_unit: scenario tasks plus randomized accesses
// checked against a transaction-level model of PC/IR/MDR and access timing.
module tb_mem_fetch_unit;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write, adr_src, mem_write, ir_write, acc_start;
  logic [31:0] pc_next, alu_out, write_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] pc, old_pc, instr, data;
  logic        busy, done, mem_err;

  always #5 clk = ~clk;

  mem_fetch_unit #(
    .XLEN(32), .RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .acc_start(acc_start),
    .pc_next(pc_next), .alu_out(alu_out), .write_data(write_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .pc(pc), .old_pc(old_pc), .instr(instr),
    .data(data), .busy(busy), .done(done), .mem_err(mem_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of the architectural registers
  logic [31:0] m_pc, m_instr, m_old_pc, m_data;

  // Observations collected by run_access
  int          o_done_n, o_done_cyc, o_err_n, o_err_cyc, o_busy_n, o_req_n;
  bit          o_stable;
  logic [31:0] o_addr, o_wdata;
  logic        o_we;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    pc_write = 0; adr_src = 0; mem_write = 0; ir_write = 0; acc_start = 0;
    pc_next = 0; alu_out = 0; write_data = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  // Drives one access and plays the memory: grant after g_dly request cycles,
  // read data r_dly cycles after grant (0 = same cycle, <0 = never).
  task automatic run_access(input bit a_src, input bit m_wr, input bit i_wr,
                            input logic [31:0] a_out, input logic [31:0] w_data,
                            input logic [31:0] r_data, input int g_dly,
                            input int r_dly, input int pcw_cyc,
                            input logic [31:0] pcw_val, input int restart_cyc,
                            input bit spur, input int n_cycles);
    int req_seen = 0;
    bit granted = 0;
    int since = 0;
    bit rv_sent = 0;
    o_done_n = 0; o_done_cyc = -1; o_err_n = 0; o_err_cyc = -1;
    o_busy_n = 0; o_req_n = 0; o_stable = 1; o_addr = 'x; o_wdata = 'x; o_we = 1'bx;
    adr_src = a_src; mem_write = m_wr; ir_write = i_wr; alu_out = a_out;
    write_data = w_data; acc_start = 1; pc_write = 0; mem_gnt = 0; mem_rvalid = 0;
    for (int c = 1; c <= n_cycles; c++) begin
      tick;
      acc_start = (c == restart_cyc);
      if (c == restart_cyc) begin
        adr_src = 1; alu_out = 32'h0000_0203; mem_write = 0; ir_write = 0;
      end
      pc_write = (c == pcw_cyc);
      pc_next  = pcw_val;
      if (done) begin o_done_n++; if (o_done_cyc < 0) o_done_cyc = c; end
      if (mem_err) begin o_err_n++; if (o_err_cyc < 0) o_err_cyc = c; end
      if (busy) o_busy_n++;
      if (mem_req) begin
        if (o_req_n == 0) begin
          o_addr = mem_addr; o_wdata = mem_wdata; o_we = mem_we;
        end else if (mem_addr !== o_addr || mem_we !== o_we || mem_wdata !== o_wdata) begin
          o_stable = 0;
        end
        o_req_n++;
      end
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
      if (granted && !m_wr && r_dly > 0 && !rv_sent) begin
        since++;
        if (since == r_dly) begin mem_rvalid = 1; mem_rdata = r_data; rv_sent = 1; end
      end
      if (mem_req && !granted) begin
        req_seen++;
        if (req_seen > g_dly) begin
          mem_gnt = 1; granted = 1;
          if (!m_wr && r_dly == 0) begin mem_rvalid = 1; mem_rdata = r_data; rv_sent = 1; end
        end else if (spur) begin
          mem_rvalid = 1'($urandom_range(0, 1));
        end
      end
    end
    idle_inputs;
  endtask

  task automatic test_reset;
    idle_inputs;
    rst_n = 0;
    tick; tick;
    rst_n = 1;
    m_pc = 32'h0; m_instr = 0; m_old_pc = 0; m_data = 0;
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    n_cmp++; if ({old_pc, instr, data} !== 96'h0) begin n_err++; $display("[TB] FAIL reset_regs: got %h expected 0", {old_pc, instr, data}); end
    n_cmp++; if ({mem_addr, mem_wdata} !== 64'h0) begin n_err++; $display("[TB] FAIL reset_mem_bus: got %h expected 0", {mem_addr, mem_wdata}); end
    n_cmp++; if ({mem_req, mem_we, busy, done, mem_err} !== 5'b0) begin n_err++; $display("[TB] FAIL reset_flags: got %b expected 00000", {mem_req, mem_we, busy, done, mem_err}); end
  endtask

  task automatic test_fetch;
    run_access(0, 0, 1, 32'h0000_0555, 32'h0, 32'h0050_0093, 1, 2, -1, 0, -1, 0, 10);
    m_instr = 32'h0050_0093; m_old_pc = 32'h0;
    n_cmp++; if (o_addr !== 32'h0) begin n_err++; $display("[TB] FAIL fetch_addr: got %h expected %h", o_addr, 32'h0); end
    n_cmp++; if (instr !== m_instr) begin n_err++; $display("[TB] FAIL fetch_instr: got %h expected %h", instr, m_instr); end
    n_cmp++; if (old_pc !== m_old_pc) begin n_err++; $display("[TB] FAIL fetch_old_pc: got %h expected %h", old_pc, m_old_pc); end
    n_cmp++; if (o_done_n !== 1) begin n_err++; $display("[TB] FAIL fetch_done_count: got %0d expected 1", o_done_n); end
    n_cmp++; if (o_busy_n !== 4) begin n_err++; $display("[TB] FAIL fetch_busy_cycles: got %0d expected 4", o_busy_n); end
    n_cmp++; if (o_done_cyc !== 5) begin n_err++; $display("[TB] FAIL fetch_done_cycle: got %0d expected 5", o_done_cyc); end
    n_cmp++; if (data !== m_data) begin n_err++; $display("[TB] FAIL fetch_data_untouched: got %h expected %h", data, m_data); end
  endtask

  task automatic test_store;
    run_access(1, 1, 0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 3, 0, -1, 0, -1, 1, 10);
    n_cmp++; if (o_req_n !== 4) begin n_err++; $display("[TB] FAIL store_req_cycles: got %0d expected 4", o_req_n); end
    n_cmp++; if (o_stable !== 1'b1) begin n_err++; $display("[TB] FAIL store_stable: got %0d expected 1", o_stable); end
    n_cmp++; if ({o_we, o_addr, o_wdata} !== {1'b1, 32'h100, 32'hDEAD_BEEF}) begin n_err++; $display("[TB] FAIL store_bus: got %b %h %h expected 1 00000100 deadbeef", o_we, o_addr, o_wdata); end
    n_cmp++; if (o_done_cyc !== 5 || o_done_n !== 1) begin n_err++; $display("[TB] FAIL store_done: got cycle %0d count %0d expected cycle 5 count 1", o_done_cyc, o_done_n); end
    n_cmp++; if ({instr, data} !== {m_instr, m_data}) begin n_err++; $display("[TB] FAIL store_regs_untouched: got %h %h expected %h %h", instr, data, m_instr, m_data); end
  endtask

  task automatic test_zero_latency_load;
    run_access(1, 0, 0, 32'h0000_0104, 32'h0, 32'h1234_5678, 0, 0, -1, 0, -1, 0, 5);
    m_data = 32'h1234_5678;
    n_cmp++; if (data !== m_data) begin n_err++; $display("[TB] FAIL zl_load_data: got %h expected %h", data, m_data); end
    n_cmp++; if (o_done_cyc !== 2) begin n_err++; $display("[TB] FAIL zl_load_done_cycle: got %0d expected 2", o_done_cyc); end
    n_cmp++; if (o_busy_n !== 1) begin n_err++; $display("[TB] FAIL zl_load_busy_cycles: got %0d expected 1", o_busy_n); end
    n_cmp++; if ({instr, old_pc} !== {m_instr, m_old_pc}) begin n_err++; $display("[TB] FAIL zl_load_ir_untouched: got %h %h expected %h %h", instr, old_pc, m_instr, m_old_pc); end
  endtask

  task automatic test_misaligned;
    run_access(1, 0, 0, 32'h0000_0102, 32'h0, 32'hAAAA_5555, 0, 0, -1, 0, -1, 0, 4);
    n_cmp++; if (o_req_n !== 0) begin n_err++; $display("[TB] FAIL misaligned_req: got %0d expected 0", o_req_n); end
    n_cmp++; if (o_err_n !== 1 || o_err_cyc !== 1) begin n_err++; $display("[TB] FAIL misaligned_err: got count %0d cycle %0d expected count 1 cycle 1", o_err_n, o_err_cyc); end
    n_cmp++; if (o_busy_n !== 0 || o_done_n !== 0) begin n_err++; $display("[TB] FAIL misaligned_idle: got busy %0d done %0d expected 0 0", o_busy_n, o_done_n); end
    n_cmp++; if (data !== m_data) begin n_err++; $display("[TB] FAIL misaligned_data: got %h expected %h", data, m_data); end
  endtask

  task automatic test_pc_update;
    logic [31:0] rd;
    rd = $urandom;
    run_access(0, 0, 1, 32'h0, 32'h0, rd, 1, 2, 1, 32'h4, 3, 0, 10);
    m_pc = 32'h4; m_instr = rd; m_old_pc = 32'h0;
    n_cmp++; if (pc !== m_pc) begin n_err++; $display("[TB] FAIL pcupd_pc: got %h expected %h", pc, m_pc); end
    n_cmp++; if (o_addr !== 32'h0 || o_stable !== 1'b1) begin n_err++; $display("[TB] FAIL pcupd_addr: got %h stable %0d expected 0 stable 1", o_addr, o_stable); end
    n_cmp++; if (old_pc !== m_old_pc || instr !== m_instr) begin n_err++; $display("[TB] FAIL pcupd_ir: got %h %h expected %h %h", old_pc, instr, m_old_pc, m_instr); end
    n_cmp++; if (o_done_n !== 1 || o_err_n !== 0) begin n_err++; $display("[TB] FAIL pcupd_restart_ignored: got done %0d err %0d expected 1 0", o_done_n, o_err_n); end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    run_access(0, 0, 1, 32'h0, 32'h0, 32'h0, 0, -1, -1, 0, -1, 0, 14);
    n_cmp++; if (o_err_n !== 1 || o_err_cyc !== TMO + 1) begin n_err++; $display("[TB] FAIL timeout_err: got count %0d cycle %0d expected count 1 cycle %0d", o_err_n, o_err_cyc, TMO + 1); end
    n_cmp++; if (o_done_n !== 0 || o_busy_n !== TMO) begin n_err++; $display("[TB] FAIL timeout_done_busy: got done %0d busy %0d expected 0 %0d", o_done_n, o_busy_n, TMO); end
    n_cmp++; if (instr !== m_instr || busy !== 1'b0) begin n_err++; $display("[TB] FAIL timeout_state: got instr %h busy %b expected %h 0", instr, busy, m_instr); end
  endtask
`else
  task automatic test_timeout;
    logic [31:0] rd;
    rd = $urandom;
    run_access(0, 0, 1, 32'h0, 32'h0, 32'h0, 0, -1, -1, 0, -1, 0, 20);
    n_cmp++; if (o_busy_n !== 20 || o_err_n !== 0 || o_done_n !== 0) begin n_err++; $display("[TB] FAIL wait_forever: got busy %0d err %0d done %0d expected 20 0 0", o_busy_n, o_err_n, o_done_n); end
    mem_rvalid = 1; mem_rdata = rd;
    tick;
    mem_rvalid = 0;
    m_instr = rd; m_old_pc = m_pc;
    n_cmp++; if (done !== 1'b1 || instr !== m_instr || old_pc !== m_old_pc) begin n_err++; $display("[TB] FAIL wait_complete: got done %b instr %h old_pc %h expected 1 %h %h", done, instr, old_pc, m_instr, m_old_pc); end
    tick;
  endtask
`endif

  task automatic test_random;
    for (int it = 0; it < 40; it++) begin
      bit          a_src, m_wr, i_wr, fetch, mis, spur;
      logic [31:0] a_out, w_data, r_data, addr;
      int          g, r, exp_busy;
      if ($urandom_range(0, 1) == 1) begin
        pc_next = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 7) == 0) pc_next[1:0] = 2'($urandom_range(1, 3));
        pc_write = 1;
        m_pc = pc_next;
        tick;
        pc_write = 0;
      end
      a_src = 1'($urandom_range(0, 1));
      m_wr = 1'($urandom_range(0, 1));
      i_wr = 1'($urandom_range(0, 1));
      spur = 1'($urandom_range(0, 1));
      a_out = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 5) == 0) a_out[1:0] = 2'($urandom_range(1, 3));
      w_data = $urandom; r_data = $urandom;
      g = $urandom_range(0, 3); r = $urandom_range(0, 3);
      addr = a_src ? a_out : m_pc;
      mis = (addr[1:0] != 2'b00);
      fetch = i_wr && !m_wr;
      run_access(a_src, m_wr, i_wr, a_out, w_data, r_data, g, r, -1, 0, -1, spur, g + r + 4);
      if (mis) begin
        n_cmp++; if (o_err_n !== 1 || o_req_n !== 0 || o_busy_n !== 0 || o_done_n !== 0) begin n_err++; $display("[TB] FAIL rnd_misaligned it%0d: got err %0d req %0d busy %0d done %0d expected 1 0 0 0", it, o_err_n, o_req_n, o_busy_n, o_done_n); end
      end else begin
        exp_busy = m_wr ? g + 1 : g + 1 + r;
        if (!m_wr) begin
          if (fetch) begin m_instr = r_data; m_old_pc = addr; end
          else m_data = r_data;
        end
        n_cmp++; if (o_addr !== addr || o_we !== m_wr || o_stable !== 1'b1) begin n_err++; $display("[TB] FAIL rnd_bus it%0d: got %h we %b stable %0d expected %h we %b stable 1", it, o_addr, o_we, o_stable, addr, m_wr); end
        n_cmp++; if (o_busy_n !== exp_busy || o_done_cyc !== exp_busy + 1 || o_done_n !== 1 || o_err_n !== 0) begin n_err++; $display("[TB] FAIL rnd_timing it%0d: got busy %0d done_cyc %0d done %0d err %0d expected %0d %0d 1 0", it, o_busy_n, o_done_cyc, o_done_n, o_err_n, exp_busy, exp_busy + 1); end
      end
      n_cmp++; if ({pc, instr, old_pc, data} !== {m_pc, m_instr, m_old_pc, m_data}) begin n_err++; $display("[TB] FAIL rnd_regs it%0d: got %h %h %h %h expected %h %h %h %h", it, pc, instr, old_pc, data, m_pc, m_instr, m_old_pc, m_data); end
    end
  endtask

  task automatic test_reset_mid;
    pc_write = 1; pc_next = 32'h0000_0040;
    tick;
    pc_write = 0; m_pc = 32'h40;
    adr_src = 0; ir_write = 1; mem_write = 0; acc_start = 1;
    tick;
    acc_start = 0; mem_gnt = 1;
    tick;
    mem_gnt = 0;
    n_cmp++; if (busy !== 1'b1 || mem_req !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_in_resp: got busy %b req %b expected 1 0", busy, mem_req); end
    rst_n = 0;
    tick;
    rst_n = 1;
    m_pc = 32'h0; m_instr = 0; m_old_pc = 0; m_data = 0;
    n_cmp++; if ({pc, old_pc, instr, data, mem_addr, mem_wdata} !== 192'h0) begin n_err++; $display("[TB] FAIL rstmid_regs: got %h expected 0", {pc, old_pc, instr, data, mem_addr, mem_wdata}); end
    n_cmp++; if ({mem_req, mem_we, busy, done, mem_err} !== 5'b0) begin n_err++; $display("[TB] FAIL rstmid_flags: got %b expected 00000", {mem_req, mem_we, busy, done, mem_err}); end
    mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    tick;
    mem_rvalid = 0;
    n_cmp++; if (done !== 1'b0 || instr !== m_instr) begin n_err++; $display("[TB] FAIL rstmid_late_rvalid: got done %b instr %h expected 0 %h", done, instr, m_instr); end
    idle_inputs;
    tick;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset;
    test_fetch;
    test_store;
    test_zero_latency_load;
    test_misaligned;
    test_pc_update;
    test_timeout;
    test_random;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
